// File: rtl/vm_return_timer_pkg.sv
// Shared definitions for the vending-machine return timer: default coin/item widths
// and the timer state encoding (IDLE=0, COUNTING=1, RETURN=2).
package vm_return_timer_pkg;

  localparam int kNumCoins = 3;
  localparam int kNumItems = 4;

  typedef enum logic [1:0] {
    kTimerIdle     = 2'd0,
    kTimerCounting = 2'd1,
    kTimerReturn   = 2'd2
  } timer_state_e;

endpackage

// File: rtl/reload_down_counter.sv
// Reloadable saturating down-counter with clear/load/decrement controls and a zero flag.
// Control priority: clear, then load, then decrement, otherwise hold.
module reload_down_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = {CNT_W{1'b0}};
    end else if (i_load) begin
      count_d = i_load_val;
    end else if (i_dec && (count_q != {CNT_W{1'b0}})) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
  assign o_zero  = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/vm_return_timer.sv
// Inactivity timer: arms on a coin, reloads on activity, requests change return on expiry
// or manual trigger. Optional low-time warning output is built with VM_TIMER_WARN_EN.
module vm_return_timer
  import vm_return_timer_pkg::*;
#(
  parameter int N_COIN      = kNumCoins,
  parameter int N_ITEM      = kNumItems,
  parameter int CNT_W       = 16,
  parameter int WARN_CYCLES = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_COIN-1:0] i_input_coin,
  input  logic [N_ITEM-1:0] i_select_item,
  input  logic [N_ITEM-1:0] i_available_item,
  input  logic [CNT_W-1:0]  i_timeout,
  input  logic              i_balance_zero,
  input  logic              i_return_trig,
  input  logic              i_return_ack,
  output logic              o_return_req,
  output logic              o_expired,
  output logic [CNT_W-1:0]  o_wait_time,
  output logic [1:0]        o_state,
  output logic              o_warn
);

  timer_state_e     state_q, state_d;
  logic             coin, sel, act;
  logic             cnt_clear, cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt;
  logic             return_req_q, return_req_d;
  logic             expired_q, expired_d;

  assign coin = |i_input_coin;
  assign sel  = |(i_select_item & i_available_item);
  assign act  = coin | sel;

  reload_down_counter #(.CNT_W(CNT_W)) u_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (cnt_clear),
    .i_load     (cnt_load),
    .i_load_val (i_timeout),
    .i_dec      (cnt_dec),
    .o_count    (cnt),
    .o_zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= kTimerIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and counter controls; COUNTING branches are in priority order.
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state_q)
      kTimerIdle: begin
        if (coin) begin
          state_d  = kTimerCounting;
          cnt_load = 1'b1;
        end else begin
          state_d = kTimerIdle;
        end
      end
      kTimerCounting: begin
        if (i_return_trig) begin
          state_d   = kTimerReturn;
          cnt_clear = 1'b1;
        end else if (act) begin
          cnt_load = 1'b1;
        end else if (i_balance_zero) begin
          state_d   = kTimerIdle;
          cnt_clear = 1'b1;
        end else if (cnt_zero) begin
          state_d = kTimerReturn;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      kTimerReturn: begin
        cnt_clear = 1'b1;
        if (i_return_ack) begin
          state_d = kTimerIdle;
        end else begin
          state_d = kTimerReturn;
        end
      end
      default: begin
        state_d   = kTimerIdle;
        cnt_clear = 1'b1;
      end
    endcase
  end

  // Expiry is a COUNTING->RETURN transition not caused by the manual trigger.
  always_comb begin
    return_req_d = (state_d == kTimerReturn);
    expired_d    = (state_q == kTimerCounting) && (state_d == kTimerReturn) && !i_return_trig;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      return_req_q <= 1'b0;
      expired_q    <= 1'b0;
    end else begin
      return_req_q <= return_req_d;
      expired_q    <= expired_d;
    end
  end

`ifdef VM_TIMER_WARN_EN
  logic warn_q, warn_d;

  // Predict the next counter value's threshold test so the flag moves with the counter.
  always_comb begin
    warn_d = 1'b0;
    if (state_d != kTimerCounting) begin
      warn_d = 1'b0;
    end else if (cnt_load) begin
      warn_d = (i_timeout <= CNT_W'(WARN_CYCLES));
    end else if (cnt_dec) begin
      warn_d = ({1'b0, cnt} <= (CNT_W+1)'(WARN_CYCLES + 1));
    end else begin
      warn_d = (cnt <= CNT_W'(WARN_CYCLES));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign o_warn = warn_q;
`else
  assign o_warn = 1'b0;
`endif

  assign o_return_req = return_req_q;
  assign o_expired    = expired_q;
  assign o_wait_time  = cnt;
  assign o_state      = state_q;

endmodule

// File: tb/tb_vm_return_timer.sv
// Self-checking bench for vm_return_timer: directed table, hand-written corner sequences
// and randomized traffic against a behavioural model.
module tb_vm_return_timer;

`ifdef VM_TIMER_WARN_EN
  localparam bit WARN_EN = 1'b1;
`else
  localparam bit WARN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  i_input_coin = 3'd0;
  logic [3:0]  i_select_item = 4'd0;
  logic [3:0]  i_available_item = 4'd0;
  logic [15:0] i_timeout = 16'd0;
  logic        i_balance_zero = 1'b0;
  logic        i_return_trig = 1'b0;
  logic        i_return_ack = 1'b0;
  logic        o_return_req, o_expired, o_warn;
  logic [15:0] o_wait_time;
  logic [1:0]  o_state;

  int n_vec = 0;
  int n_err = 0;

  // behavioural reference state
  int m_state, m_wait;
  bit m_req, m_exp, m_warn;

  typedef struct {
    logic [2:0]  coin;
    logic [3:0]  sel;
    logic [3:0]  avail;
    logic [15:0] tmo;
    logic        bz, trig, ack;
    logic [1:0]  st;
    logic [15:0] wt;
    logic        req, ex;
  } vec_t;

  vec_t tbl[12];

  vm_return_timer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_input_coin     (i_input_coin),
    .i_select_item    (i_select_item),
    .i_available_item (i_available_item),
    .i_timeout        (i_timeout),
    .i_balance_zero   (i_balance_zero),
    .i_return_trig    (i_return_trig),
    .i_return_ack     (i_return_ack),
    .o_return_req     (o_return_req),
    .o_expired        (o_expired),
    .o_wait_time      (o_wait_time),
    .o_state          (o_state),
    .o_warn           (o_warn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input int st, input int wt, input bit req,
                         input bit ex, input bit wn);
    chk({nm, ".state"}, 32'(o_state), 32'(st));
    chk({nm, ".wait"}, 32'(o_wait_time), 32'(wt));
    chk({nm, ".req"}, 32'(o_return_req), 32'(req));
    chk({nm, ".expired"}, 32'(o_expired), 32'(ex));
    chk({nm, ".warn"}, 32'(o_warn), 32'(wn));
  endtask

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_req = 0; m_exp = 0; m_warn = 0;
  endtask

  // Apply the behavioural rules to the inputs present at this clock edge.
  task automatic model_step();
    bit coin, sel;
    coin  = (i_input_coin != 3'd0);
    sel   = ((i_select_item & i_available_item) != 4'd0);
    m_exp = 1'b0;
    if (m_state == 0) begin
      if (coin) begin m_state = 1; m_wait = int'(i_timeout); end
    end else if (m_state == 1) begin
      if (i_return_trig) begin m_state = 2; m_wait = 0; end
      else if (coin || sel) m_wait = int'(i_timeout);
      else if (i_balance_zero) begin m_state = 0; m_wait = 0; end
      else if (m_wait == 0) begin m_state = 2; m_exp = 1'b1; end
      else m_wait = m_wait - 1;
    end else begin
      if (i_return_ack) m_state = 0;
    end
    m_req  = (m_state == 2);
    m_warn = WARN_EN && (m_state == 1) && (m_wait <= 10);
  endtask

  task automatic drv(input logic [2:0] c = 3'd0, input logic [3:0] s = 4'd0,
                     input logic [3:0] a = 4'd0, input logic [15:0] t = 16'd5,
                     input logic bz = 1'b0, input logic tr = 1'b0, input logic ak = 1'b0);
    i_input_coin = c; i_select_item = s; i_available_item = a; i_timeout = t;
    i_balance_zero = bz; i_return_trig = tr; i_return_ack = ak;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
  endtask

  initial begin
    // coin, sel, avail, timeout, bz, trig, ack -> state, wait, req, expired
    tbl[0]  = '{3'b001, 4'd0, 4'd0, 16'd5, 1'b0, 1'b0, 1'b0, 2'd1, 16'd5, 1'b0, 1'b0};
    tbl[1]  = '{3'b000, 4'd0, 4'd0, 16'd9, 1'b0, 1'b0, 1'b0, 2'd1, 16'd4, 1'b0, 1'b0};
    tbl[2]  = '{3'b000, 4'd0, 4'd0, 16'd9, 1'b0, 1'b0, 1'b0, 2'd1, 16'd3, 1'b0, 1'b0};
    tbl[3]  = '{3'b000, 4'd0, 4'd0, 16'd9, 1'b0, 1'b0, 1'b1, 2'd1, 16'd2, 1'b0, 1'b0};
    tbl[4]  = '{3'b000, 4'd0, 4'd0, 16'd9, 1'b0, 1'b0, 1'b0, 2'd1, 16'd1, 1'b0, 1'b0};
    tbl[5]  = '{3'b000, 4'd0, 4'd0, 16'd9, 1'b0, 1'b0, 1'b0, 2'd1, 16'd0, 1'b0, 1'b0};
    tbl[6]  = '{3'b000, 4'd0, 4'd0, 16'd9, 1'b0, 1'b0, 1'b0, 2'd2, 16'd0, 1'b1, 1'b1};
    tbl[7]  = '{3'b010, 4'd0, 4'd0, 16'd9, 1'b0, 1'b0, 1'b0, 2'd2, 16'd0, 1'b1, 1'b0};
    tbl[8]  = '{3'b000, 4'd0, 4'd0, 16'd9, 1'b0, 1'b1, 1'b0, 2'd2, 16'd0, 1'b1, 1'b0};
    tbl[9]  = '{3'b000, 4'd0, 4'd0, 16'd9, 1'b0, 1'b0, 1'b1, 2'd0, 16'd0, 1'b0, 1'b0};
    tbl[10] = '{3'b000, 4'd0, 4'd0, 16'd9, 1'b0, 1'b0, 1'b1, 2'd0, 16'd0, 1'b0, 1'b0};
    tbl[11] = '{3'b000, 4'b0011, 4'b0001, 16'd9, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0};

    model_reset();
    repeat (2) @(negedge clk);
    chk_out("reset_held", 0, 0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();
    chk_out("reset_release", 0, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].coin, tbl[i].sel, tbl[i].avail, tbl[i].tmo, tbl[i].bz, tbl[i].trig, tbl[i].ack);
      step();
      chk_out($sformatf("tbl%0d", i), int'(tbl[i].st), int'(tbl[i].wt), tbl[i].req, tbl[i].ex, 1'b0);
    end

    // reload by valid select, no reload by unavailable select
    drv(3'b001); step();
    drv(); repeat (3) step();
    chk_out("pre_sel", 1, 2, 1'b0, 1'b0, 1'b0);
    drv(3'd0, 4'b0010, 4'b0010); step();
    chk_out("sel_reload", 1, 5, 1'b0, 1'b0, 1'b0);
    drv(); repeat (3) step();
    drv(3'd0, 4'b0100, 4'b0010); step();
    chk_out("sel_unavail", 1, 1, 1'b0, 1'b0, 1'b0);
    drv(); step();
    chk_out("at_zero", 1, 0, 1'b0, 1'b0, 1'b0);
    drv(3'b100); step();
    chk_out("coin_on_expiry", 1, 5, 1'b0, 1'b0, 1'b0);

    // trigger beats coin, coins ignored in RETURN
    drv(3'b001, 4'd0, 4'd0, 16'd5, 1'b0, 1'b1); step();
    chk_out("trig_coin", 2, 0, 1'b1, 1'b0, 1'b0);
    drv(3'b011); step();
    chk_out("ret_coin", 2, 0, 1'b1, 1'b0, 1'b0);
    drv(3'd0, 4'd0, 4'd0, 16'd5, 1'b0, 1'b0, 1'b1); step();
    chk_out("ret_ack", 0, 0, 1'b0, 1'b0, 1'b0);

    // zero timeout expires the cycle after the load
    drv(3'b001, 4'd0, 4'd0, 16'd0); step();
    chk_out("t0_load", 1, 0, 1'b0, 1'b0, WARN_EN);
    drv(); step();
    chk_out("t0_expire", 2, 0, 1'b1, 1'b1, 1'b0);
    drv(3'd0, 4'd0, 4'd0, 16'd5, 1'b0, 1'b0, 1'b1); step();

    // balance zero with no activity returns to IDLE without a request
    drv(3'b001); step();
    drv(); step();
    drv(3'd0, 4'd0, 4'd0, 16'd5, 1'b1); step();
    chk_out("bal_zero", 0, 0, 1'b0, 1'b0, 1'b0);
    drv(); repeat (3) step();
    chk_out("bal_zero_idle", 0, 0, 1'b0, 1'b0, 1'b0);

    // warning threshold, then asynchronous reset mid-count
    drv(3'b001, 4'd0, 4'd0, 16'd20); step();
    drv(); repeat (9) step();
    chk_out("warn_11", 1, 11, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("warn_10", 1, 10, 1'b0, 1'b0, WARN_EN);
    async_reset();
    chk_out("async_count", 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) reset_n = 1'b1;

    // asynchronous reset aborts RETURN; no ack needed afterwards
    drv(3'b001, 4'd0, 4'd0, 16'd0); step();
    drv(); step();
    chk_out("pre_async_ret", 2, 0, 1'b1, 1'b1, 1'b0);
    async_reset();
    chk_out("async_ret", 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    step();
    chk_out("after_async_ret", 0, 0, 1'b0, 1'b0, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drv(($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
          ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0,
          4'($urandom),
          16'($urandom_range(0, 14)),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 3) == 0));
      step();
      chk_out($sformatf("rnd%0d", i), m_state, m_wait, m_req, m_exp, m_warn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
